// File: rtl/rd53_cdac_ramp_ctrl_if.sv
// ---------------------------------------------------------------------------
// rd53_cdac_ramp_ctrl_if
//   Config write channel into the CDAC ramp controller.
//   Signals:
//     wr_valid  master -> slave  write request
//     wr_ready  slave  -> master controller can accept a write this cycle
//     wr_addr   master -> slave  target channel index
//     wr_data   master -> slave  10-bit target code
//   Modports: master (config register block), slave (ramp controller).
// ---------------------------------------------------------------------------
interface rd53_cdac_ramp_ctrl_if #(
  parameter int N_DAC = 4,
  parameter int AW    = (N_DAC > 1) ? $clog2(N_DAC) : 1
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [9:0]    wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/rd53_cdac_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// rd53_cdac_ramp_ctrl
//   Slew-limited sequencer for N_DAC 10-bit bias DACs. Target codes arrive on
//   the config write channel; the controller walks each DAC's current code
//   toward its target by at most STEP per update, updating one channel per
//   tick, choosing channels round-robin.
//   Ports:
//     clk      system clock, all state on rising edge
//     rst_b    asynchronous active-low reset
//     wr       config write channel (slave modport)
//     ramp_en  1 = ramping allowed, 0 = freeze current codes
//     bin_out  current codes, channel i on [10*i +: 10] (registered)
//     done     bit i = (current code i == target i)
//     busy     sequencer not idle
//     err      1-cycle pulse: a write to a nonexistent channel was dropped
// ---------------------------------------------------------------------------
module rd53_cdac_ramp_ctrl #(
  parameter int N_DAC      = 4,
  parameter int STEP       = 8,
  parameter int TICK_DIV   = 16,
  parameter int RESET_CODE = 0
) (
  input  logic                   clk,
  input  logic                   rst_b,
  rd53_cdac_ramp_ctrl_if.slave   wr,
  input  logic                   ramp_en,
  output logic [10*N_DAC-1:0]    bin_out,
  output logic [N_DAC-1:0]       done,
  output logic                   busy,
  output logic                   err
);

  localparam int PW = (N_DAC > 1) ? $clog2(N_DAC) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TW-1:0]       TIMER_LOAD = TW'(TICK_DIV - 1);
  localparam logic [9:0]          RST_CODE   = 10'(RESET_CODE);
  localparam logic [9:0]          STEP_U     = 10'(STEP);
  localparam logic signed [10:0]  STEP_S     = 11'(STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TIMER = 2'd1,
    S_SCAN  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [PW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic            err_reg;

  logic [9:0]      cur_reg [N_DAC];
  logic [9:0]      tgt_reg [N_DAC];

  logic [N_DAC-1:0] pending;
  logic [N_DAC-1:0] pending_after;
  logic             wr_accept;
  logic             wr_in_range;
  logic [PW-1:0]    sel;
  logic             sel_found;
  int               scan_idx;
  logic [9:0]       cur_sel;
  logic [9:0]       tgt_sel;
  logic signed [10:0] diff;
  logic [9:0]       cur_new;
  logic             still_pending;
  logic             scan_upd;

  assign wr_accept   = wr.wr_valid & wr.wr_ready;
  assign wr_in_range = (int'(wr.wr_addr) < N_DAC);
  assign scan_upd    = (state_reg == S_SCAN) && sel_found;

  genvar gi;
  generate
    for (gi = 0; gi < N_DAC; gi++) begin : g_ch
      assign pending[gi]            = (cur_reg[gi] != tgt_reg[gi]);
      assign done[gi]               = ~pending[gi];
      assign bin_out[10*gi +: 10]   = cur_reg[gi];
    end
  endgenerate

  // First pending channel at or after rr_ptr, wrapping around the bank.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    scan_idx  = 0;
    for (int k = 0; k < N_DAC; k++) begin
      scan_idx = int'(rr_ptr_reg) + k;
      if (scan_idx >= N_DAC) begin
        scan_idx = scan_idx - N_DAC;
      end
      if (!sel_found && pending[scan_idx]) begin
        sel_found = 1'b1;
        sel       = PW'(scan_idx);
      end
    end
  end

  // Slew-limited update of the selected channel. The difference is taken in
  // 11-bit signed so both directions are exact; when the remaining distance
  // is within STEP the code lands exactly on the target, so no wrap occurs.
  always_comb begin
    cur_sel = cur_reg[sel];
    tgt_sel = tgt_reg[sel];
    diff    = $signed({1'b0, tgt_sel}) - $signed({1'b0, cur_sel});
    cur_new = cur_sel;
    if (diff > 0) begin
      cur_new = (diff > STEP_S) ? (cur_sel + STEP_U) : tgt_sel;
    end else if (diff < 0) begin
      cur_new = ((-diff) > STEP_S) ? (cur_sel - STEP_U) : tgt_sel;
    end
    pending_after      = pending;
    pending_after[sel] = (cur_new != tgt_sel);
    still_pending      = |pending_after;
  end

  // State register plus the error pulse.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg  <= S_IDLE;
      timer_reg  <= '0;
      rr_ptr_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      rr_ptr_reg <= rr_ptr_next;
      err_reg    <= wr_accept & ~wr_in_range;
    end
  end

  // Code registers. Writes never coincide with a SCAN update because the
  // write channel is stalled during SCAN.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < N_DAC; i++) begin
        cur_reg[i] <= RST_CODE;
        tgt_reg[i] <= RST_CODE;
      end
    end else begin
      for (int i = 0; i < N_DAC; i++) begin
        if (wr_accept && wr_in_range && (int'(wr.wr_addr) == i)) begin
          tgt_reg[i] <= wr.wr_data;
        end
        if (scan_upd && (int'(sel) == i)) begin
          cur_reg[i] <= cur_new;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      S_IDLE: begin
        if (ramp_en && (|pending)) begin
          state_next = S_TIMER;
          timer_next = TIMER_LOAD;
        end
      end
      S_TIMER: begin
        if (!ramp_en) begin
          state_next = S_IDLE;
          timer_next = '0;
        end else if (timer_reg == '0) begin
          state_next = S_SCAN;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      S_SCAN: begin
        state_next = S_IDLE;
        if (sel_found) begin
          rr_ptr_next = (int'(sel) == N_DAC - 1) ? '0 : (sel + 1'b1);
          if (still_pending && ramp_en) begin
            state_next = S_TIMER;
            timer_next = TIMER_LOAD;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        timer_next = '0;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    busy        = (state_reg != S_IDLE);
    wr.wr_ready = (state_reg != S_SCAN);
    err         = err_reg;
  end

endmodule

// File: tb/tb_rd53_cdac_ramp_ctrl.sv
module tb_rd53_cdac_ramp_ctrl;
  localparam int N    = 4;
  localparam int STEP = 8;
  localparam int TD   = 16;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic ramp_en = 1'b0;
  logic ramp_en3 = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rd53_cdac_ramp_ctrl_if #(.N_DAC(N)) wr_if ();
  logic [10*N-1:0] bin_out;
  logic [N-1:0]    done;
  logic            busy, err;

  rd53_cdac_ramp_ctrl #(.N_DAC(N), .STEP(STEP), .TICK_DIV(TD), .RESET_CODE(0)) dut (
    .clk(clk), .rst_b(rst_b), .wr(wr_if), .ramp_en(ramp_en),
    .bin_out(bin_out), .done(done), .busy(busy), .err(err)
  );

  rd53_cdac_ramp_ctrl_if #(.N_DAC(3)) wr3_if ();
  logic [29:0] bin_out3;
  logic [2:0]  done3;
  logic        busy3, err3;

  rd53_cdac_ramp_ctrl #(.N_DAC(3), .STEP(STEP), .TICK_DIV(TD), .RESET_CODE(0)) dut3 (
    .clk(clk), .rst_b(rst_b), .wr(wr3_if), .ramp_en(ramp_en3),
    .bin_out(bin_out3), .done(done3), .busy(busy3), .err(err3)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: codes, targets and the round-robin start point.
  int m_cur[N];
  int m_tgt[N];
  int m_rr;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_cur[i] = 0;
      m_tgt[i] = 0;
    end
    m_rr = 0;
  endfunction

  function automatic bit model_pending();
    for (int i = 0; i < N; i++) if (m_cur[i] != m_tgt[i]) return 1'b1;
    return 1'b0;
  endfunction

  // One update: first channel off target starting at m_rr, moved by at most STEP.
  function automatic int model_step();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_rr + k) % N;
      if (m_cur[j] != m_tgt[j]) begin
        int d;
        d = m_tgt[j] - m_cur[j];
        if (d > STEP) m_cur[j] += STEP;
        else if (d < -STEP) m_cur[j] -= STEP;
        else m_cur[j] = m_tgt[j];
        m_rr = (j + 1) % N;
        return j;
      end
    end
    return -1;
  endfunction

  function automatic logic [10*N-1:0] model_bin();
    logic [10*N-1:0] v;
    for (int i = 0; i < N; i++) v[10*i +: 10] = 10'(m_cur[i]);
    return v;
  endfunction

  function automatic logic [N-1:0] model_done();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (m_cur[i] == m_tgt[i]);
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int ch, input int data, output int edge_no);
    int guard;
    guard = 0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = 2'(ch);
    wr_if.wr_data  = 10'(data);
    while (!wr_if.wr_ready && guard < 40) begin
      tick(1);
      guard++;
    end
    tick(1);
    edge_no = cyc;
    wr_if.wr_valid = 1'b0;
    m_tgt[ch] = data;
    $display("write ch%0d = %0d accepted at edge %0d", ch, data, edge_no);
  endtask

  // Advance until bin_out changes (bounded); also records cycles with wr_ready low.
  task automatic wait_step(output int edge_no, output int low_cnt, output int low_cyc, output bit ok);
    logic [10*N-1:0] prev_bin;
    ok = 1'b0; low_cnt = 0; low_cyc = -1; edge_no = cyc;
    for (int i = 0; i < 40; i++) begin
      if (!wr_if.wr_ready) begin
        low_cnt++;
        low_cyc = cyc;
      end
      prev_bin = bin_out;
      tick(1);
      if (bin_out !== prev_bin) begin
        ok = 1'b1;
        edge_no = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    wr_if.wr_valid = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0;
    wr3_if.wr_valid = 1'b0; wr3_if.wr_addr = '0; wr3_if.wr_data = '0;
    model_reset();
    tick(3);
    checks++; if (bin_out !== '0) begin errors++; $display("FAIL reset_bin got %h want 0", bin_out); end
    checks++; if (done !== 4'hF) begin errors++; $display("FAIL reset_done got %h want F", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", wr_if.wr_ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    rst_b = 1'b1;
    tick(2);
    $display("reset released at edge %0d", cyc);
  endtask

  task automatic test_single_ramp();
    int e0, e, prev, lo, lc, j;
    bit ok;
    ramp_en = 1'b1;
    do_write(0, 100, e0);
    prev = e0;
    for (int s = 0; s < 13; s++) begin
      wait_step(e, lo, lc, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_timeout step %0d: no change, want one", s); break; end
      j = model_step();
      $display("single step ch%0d -> %0d at edge %0d", j, m_cur[0], e);
      checks++; if (bin_out !== model_bin()) begin errors++; $display("FAIL single_bin got %h want %h", bin_out, model_bin()); end
      checks++; if (e - prev !== ((s == 0) ? TD + 2 : TD + 1)) begin errors++; $display("FAIL single_gap got %0d want %0d", e - prev, (s == 0) ? TD + 2 : TD + 1); end
      prev = e;
    end
    checks++; if (bin_out[9:0] !== 10'd100) begin errors++; $display("FAIL single_final got %0d want 100", bin_out[9:0]); end
    checks++; if (done !== 4'hF) begin errors++; $display("FAIL single_done got %h want F", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int e0, e1, e, prev, lo, lc, j, s;
    bit ok;
    int exp_order[5] = '{1, 2, 1, 2, 1};
    do_write(1, 20, e0);
    do_write(2, 1023, e1);
    prev = e0; s = 0;
    while (model_pending() && s < 300) begin
      wait_step(e, lo, lc, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rr_timeout step %0d: no change, want one", s); break; end
      j = model_step();
      $display("rr step ch%0d -> %0d at edge %0d", j, m_cur[j], e);
      if (s < 5) begin
        checks++; if (j !== exp_order[s]) begin errors++; $display("FAIL rr_order step %0d model ch%0d want ch%0d", s, j, exp_order[s]); end
      end
      checks++; if (bin_out !== model_bin()) begin errors++; $display("FAIL rr_bin got %h want %h", bin_out, model_bin()); end
      checks++; if (done !== model_done()) begin errors++; $display("FAIL rr_done got %h want %h", done, model_done()); end
      checks++; if (e - prev !== ((s == 0) ? TD + 2 : TD + 1)) begin errors++; $display("FAIL rr_gap got %0d want %0d", e - prev, (s == 0) ? TD + 2 : TD + 1); end
      prev = e; s++;
    end
    checks++; if (bin_out[29:20] !== 10'd1023) begin errors++; $display("FAIL rr_final2 got %0d want 1023", bin_out[29:20]); end
    checks++; if (bin_out[19:10] !== 10'd20) begin errors++; $display("FAIL rr_final1 got %0d want 20", bin_out[19:10]); end
  endtask

  task automatic test_retarget();
    int e0, e1, e2, e, prev, lo, lc, j, s;
    bit ok;
    do_write(0, 48, e0);
    prev = e0; s = 0;
    while (model_pending() && s < 20) begin
      wait_step(e, lo, lc, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL retgt_timeout step %0d: no change, want one", s); break; end
      j = model_step();
      $display("retarget step ch%0d -> %0d at edge %0d", j, m_cur[j], e);
      checks++; if (bin_out !== model_bin()) begin errors++; $display("FAIL retgt_bin got %h want %h", bin_out, model_bin()); end
      prev = e; s++;
    end
    checks++; if (bin_out[9:0] !== 10'd48) begin errors++; $display("FAIL retgt_at48 got %0d want 48", bin_out[9:0]); end
    do_write(0, 100, e1);
    do_write(0, 40, e2);
    wait_step(e, lo, lc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL retgt_timeout2: no change, want one"); end
    j = model_step();
    $display("retarget step ch%0d -> %0d at edge %0d", j, m_cur[j], e);
    checks++; if (bin_out[9:0] !== 10'd40) begin errors++; $display("FAIL retgt_down got %0d want 40", bin_out[9:0]); end
    checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL retgt_done got %b want 1", done[0]); end
    checks++; if (e - e1 !== TD + 2) begin errors++; $display("FAIL retgt_gap got %0d want %0d", e - e1, TD + 2); end
  endtask

  task automatic test_bad_addr();
    logic [29:0] bin_before;
    logic [2:0]  done_before;
    ramp_en3 = 1'b1;
    tick(1);
    bin_before = bin_out3; done_before = done3;
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL bad_err_pre got %b want 0", err3); end
    wr3_if.wr_valid = 1'b1; wr3_if.wr_addr = 2'd3; wr3_if.wr_data = 10'd500;
    tick(1);
    wr3_if.wr_valid = 1'b0;
    $display("bad write addr 3 = 500 at edge %0d", cyc);
    checks++; if (err3 !== 1'b1) begin errors++; $display("FAIL bad_err_pulse got %b want 1", err3); end
    checks++; if (bin_out3 !== 30'd0) begin errors++; $display("FAIL bad_bin got %h want 0", bin_out3); end
    checks++; if (done3 !== 3'b111) begin errors++; $display("FAIL bad_done got %b want 111", done3); end
    tick(1);
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL bad_err_len got %b want 0", err3); end
    tick(TD + 4);
    checks++; if (bin_out3 !== bin_before) begin errors++; $display("FAIL bad_bin_late got %h want %h", bin_out3, bin_before); end
    checks++; if (done3 !== done_before) begin errors++; $display("FAIL bad_done_late got %b want %b", done3, done_before); end
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL bad_busy got %b want 0", busy3); end
    // A legal write on the same instance still ramps and raises no error.
    wr3_if.wr_valid = 1'b1; wr3_if.wr_addr = 2'd2; wr3_if.wr_data = 10'd5;
    tick(1);
    wr3_if.wr_valid = 1'b0;
    $display("good write addr 2 = 5 at edge %0d", cyc);
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL good_err got %b want 0", err3); end
    tick(TD + 2);
    checks++; if (bin_out3 !== {10'd5, 20'd0}) begin errors++; $display("FAIL good_bin got %h want %h", bin_out3, {10'd5, 20'd0}); end
  endtask

  task automatic test_freeze();
    int e0, e1, e, prev, lo, lc, j, s, changes, r;
    bit ok;
    logic [10*N-1:0] frozen;
    do_write(3, 200, e0);
    do_write(1, 60, e1);
    wait_step(e, lo, lc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL frz_timeout0: no change, want one"); end
    j = model_step();
    $display("freeze step ch%0d -> %0d at edge %0d", j, m_cur[j], e);
    checks++; if (bin_out !== model_bin()) begin errors++; $display("FAIL frz_bin0 got %h want %h", bin_out, model_bin()); end
    tick(5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frz_busy_timer got %b want 1", busy); end
    ramp_en = 1'b0;
    tick(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frz_busy got %b want 0", busy); end
    frozen = bin_out; changes = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (bin_out !== frozen || busy !== 1'b0) changes++;
    end
    checks++; if (changes !== 0) begin errors++; $display("FAIL frz_hold got %0d changed cycles want 0", changes); end
    ramp_en = 1'b1;
    r = cyc; prev = r; s = 0;
    $display("ramp re-enabled after edge %0d", r);
    while (model_pending() && s < 60) begin
      wait_step(e, lo, lc, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL frz_timeout step %0d: no change, want one", s); break; end
      j = model_step();
      $display("freeze step ch%0d -> %0d at edge %0d", j, m_cur[j], e);
      checks++; if (bin_out !== model_bin()) begin errors++; $display("FAIL frz_bin got %h want %h", bin_out, model_bin()); end
      checks++; if (e - prev !== ((s == 0) ? TD + 2 : TD + 1)) begin errors++; $display("FAIL frz_gap got %0d want %0d", e - prev, (s == 0) ? TD + 2 : TD + 1); end
      checks++; if (lo !== 1 || lc !== e - 1) begin errors++; $display("FAIL frz_ready got %0d low cycles last at %0d want 1 at %0d", lo, lc, e - 1); end
      prev = e; s++;
    end
  endtask

  task automatic test_random();
    int e0, e, prev, lo, lc, j, s, nw, ch, val, edummy;
    bit ok;
    for (int round = 0; round < 8; round++) begin
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) begin
        ch = $urandom_range(0, N - 1);
        val = m_cur[ch] + $urandom_range(0, 160) - 80;
        if (val < 0) val = 0;
        if (val > 1023) val = 1023;
        if (w == 0 && val == m_cur[ch]) val = (val == 1023) ? 1022 : val + 1;
        do_write(ch, val, edummy);
        if (w == 0) e0 = edummy;
      end
      prev = e0; s = 0;
      while (model_pending() && s < 200) begin
        wait_step(e, lo, lc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rnd_timeout round %0d step %0d: no change, want one", round, s); break; end
        j = model_step();
        $display("random step ch%0d -> %0d at edge %0d", j, m_cur[j], e);
        checks++; if (bin_out !== model_bin()) begin errors++; $display("FAIL rnd_bin got %h want %h", bin_out, model_bin()); end
        checks++; if (done !== model_done()) begin errors++; $display("FAIL rnd_done got %h want %h", done, model_done()); end
        checks++; if (e - prev !== ((s == 0) ? TD + 2 : TD + 1)) begin errors++; $display("FAIL rnd_gap got %0d want %0d", e - prev, (s == 0) ? TD + 2 : TD + 1); end
        prev = e; s++;
        if (model_pending() && $urandom_range(0, 3) == 0) begin
          ch = $urandom_range(0, N - 1);
          val = m_cur[ch] + $urandom_range(0, 100) - 50;
          if (val < 0) val = 0;
          if (val > 1023) val = 1023;
          do_write(ch, val, edummy);
        end
      end
      tick(TD + 4);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_idle got busy %b want 0", busy); end
    end
  endtask

  task automatic test_reset_mid_ramp();
    int e0, changes;
    logic [10*N-1:0] b0;
    do_write(2, 500, e0);
    tick(30);
    #2;
    rst_b = 1'b0;
    #1;
    $display("reset asserted mid-ramp at time %0t", $time);
    checks++; if (bin_out !== '0) begin errors++; $display("FAIL mid_rst_bin got %h want 0", bin_out); end
    checks++; if (done !== 4'hF) begin errors++; $display("FAIL mid_rst_done got %h want F", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b want 1", wr_if.wr_ready); end
    tick(2);
    rst_b = 1'b1;
    model_reset();
    b0 = bin_out; changes = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (bin_out !== b0 || busy !== 1'b0) changes++;
    end
    checks++; if (changes !== 0) begin errors++; $display("FAIL mid_rst_discard got %0d active cycles want 0", changes); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_ramp();
    test_round_robin();
    test_retarget();
    test_bad_addr();
    test_freeze();
    test_random();
    test_reset_mid_ramp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
